multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports, one per line as name, direction, width, meaning; clk and rst come first.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- op_code  in  7  instr[6:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory handshake; access completes in the cycle it is high.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register.
- mem_write  out  1  data memory write strobe.
- ir_write  out  1  instruction register and old-PC load enable.
- reg_write  out  1  register file write enable.
- result_src  out  2  result mux select: 00=ALU out register, 01=data register, 10=ALU result direct.
- alu_src_a  out  2  ALU A select: 00=PC, 01=old PC, 10=rs1 register.
- alu_src_b  out  2  ALU B select: 00=rs2 register, 01=immediate, 10=constant 4.
- imm_src  out  2  immediate select: 00=I, 01=S, 10=B.
- alu_op  out  2  ALU decoder class: 00=add, 01=sub/compare, 10=funct-decoded.
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding, for debug.

Function
REQ-002 The block SHALL be a Moore FSM with a 4-bit state register: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BEQ=9, ILLEGAL=10.
REQ-003 Every output bit not listed for a state SHALL be 0 in that state.
REQ-004 FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
- ir_write=mem_ready and pc_write=mem_ready.
- Hold in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-005 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00, imm_src=10 (precomputes branch target).
- Next state by op_code: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BEQ; any other -> ILLEGAL.
REQ-006 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00.
- imm_src=00 for op_code 0000011, 01 for 0100011.
- Next state: load -> MEMRD, store -> MEMWR.
REQ-007 MEMRD: adr_src=1; hold while mem_ready=0; go to MEMWB on mem_ready=1.
REQ-008 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-009 MEMWR: adr_src=1, mem_write=1; hold while mem_ready=0; go to FETCH on mem_ready=1.
- mem_write stays high for every wait cycle.
REQ-010 EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-011 EXEC_I: alu_src_a=10, alu_src_b=01, imm_src=00, alu_op=10; next state ALUWB.
REQ-012 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-013 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, imm_src=10.
- pc_write=zero.
- Next state FETCH unconditionally.
REQ-014 ILLEGAL: illegal_instr=1 for exactly one cycle, no architectural writes, next state FETCH.
REQ-015 Any unused state encoding (11-15) SHALL behave as ILLEGAL, returning to FETCH on the next cycle.
REQ-016 Per-instruction latency with mem_ready tied high:
- lw 5 cycles; sw 4; R-type 4; I-type 4; beq 3; illegal 3.
- Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle.
REQ-017 At most one of reg_write and mem_write SHALL be high in any cycle.
- Neither SHALL be high in FETCH, DECODE, MEMADR or BEQ.

Reset
REQ-018 rst=1 at a rising edge SHALL force state=FETCH, overriding any transition including mid-wait in MEMRD or MEMWR.
REQ-019 While state=FETCH after reset, outputs SHALL follow REQ-004 combinationally; the first instruction fetch begins on the first edge with rst=0.
REQ-020 An aborted store SHALL drive mem_write=0 from the cycle state returns to FETCH onward.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- rst, mem_ready=1, op_code=0000011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with result_src=01.
- op_code=0100011, mem_ready low for 2 cycles in MEMWR -> mem_write=1 for 3 cycles, adr_src=1, then FETCH.
- op_code=1100011 with zero=1 -> pc_write=1 in BEQ; repeat with zero=0 -> pc_write=0; both return to FETCH.
- op_code=0110011 then 0010011 -> EXEC_R alu_src_b=00 vs EXEC_I alu_src_b=01; ALUWB reg_write=1 in both.
- op_code=1111111 -> illegal_instr single-cycle pulse in state 10, no reg_write/mem_write/pc_write, back to FETCH.
- rst asserted during MEMRD wait (mem_ready=0) -> state=0 next edge; mem_ready=0 in FETCH holds ir_write=0, pc_write=0.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath:
// decode/status inputs from the datapath, strobes and mux selects back to it.
interface multicycle_controller_if;
  logic [6:0] op_code;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [1:0] alu_op;
  logic       illegal_instr;
  logic [3:0] state;

  modport master (
    input  op_code, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op,
           illegal_instr, state
  );

  modport slave (
    output op_code, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_op,
           illegal_instr, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V style datapath (lw, sw, R, I, beq).
// Outputs decode from the state register; only FETCH and BEQ also look at mem_ready/zero.
module multicycle_controller (
  input  logic                           clk,
  input  logic                           rst,
  multicycle_controller_if.master        ctrl
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_ILLEGAL = 4'd10
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_e state_q;
  state_e state_d;

  // State register; reset wins over any pending transition, including memory waits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode; every output defaults to 0 and is raised per state.
  always_comb begin
    state_d            = S_FETCH;
    ctrl.pc_write      = 1'b0;
    ctrl.adr_src       = 1'b0;
    ctrl.mem_write     = 1'b0;
    ctrl.ir_write      = 1'b0;
    ctrl.reg_write     = 1'b0;
    ctrl.result_src    = 2'b00;
    ctrl.alu_src_a     = 2'b00;
    ctrl.alu_src_b     = 2'b00;
    ctrl.imm_src       = 2'b00;
    ctrl.alu_op        = 2'b00;
    ctrl.illegal_instr = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 goes straight to the PC while the instruction is latched.
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = 2'b00;
        ctrl.alu_src_b  = 2'b10;
        ctrl.alu_op     = 2'b00;
        ctrl.result_src = 2'b10;
        ctrl.ir_write   = ctrl.mem_ready;
        ctrl.pc_write   = ctrl.mem_ready;
        if (ctrl.mem_ready) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        // Branch target old_pc + imm_b is formed here so BEQ only needs the compare.
        ctrl.alu_src_a = 2'b01;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b00;
        ctrl.imm_src   = 2'b10;
        case (ctrl.op_code)
          OP_LOAD:  state_d = S_MEMADR;
          OP_STORE: state_d = S_MEMADR;
          OP_RTYPE: state_d = S_EXEC_R;
          OP_ITYPE: state_d = S_EXEC_I;
          OP_BEQ:   state_d = S_BEQ;
          default:  state_d = S_ILLEGAL;
        endcase
      end

      S_MEMADR: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.alu_op    = 2'b00;
        if (ctrl.op_code == OP_STORE) begin
          ctrl.imm_src = 2'b01;
        end else begin
          ctrl.imm_src = 2'b00;
        end
        case (ctrl.op_code)
          OP_LOAD:  state_d = S_MEMRD;
          OP_STORE: state_d = S_MEMWR;
          default:  state_d = S_ILLEGAL;
        endcase
      end

      S_MEMRD: begin
        ctrl.adr_src = 1'b1;
        if (ctrl.mem_ready) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMWB: begin
        ctrl.result_src = 2'b01;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end

      S_MEMWR: begin
        // Strobe is held for the whole wait so the memory sees a stable request.
        ctrl.adr_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        if (ctrl.mem_ready) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_EXEC_R: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b00;
        ctrl.alu_op    = 2'b10;
        state_d        = S_ALUWB;
      end

      S_EXEC_I: begin
        ctrl.alu_src_a = 2'b10;
        ctrl.alu_src_b = 2'b01;
        ctrl.imm_src   = 2'b00;
        ctrl.alu_op    = 2'b10;
        state_d        = S_ALUWB;
      end

      S_ALUWB: begin
        ctrl.result_src = 2'b00;
        ctrl.reg_write  = 1'b1;
        state_d         = S_FETCH;
      end

      S_BEQ: begin
        // ALU out register still holds the target from DECODE; the compare picks it up.
        ctrl.alu_src_a  = 2'b10;
        ctrl.alu_src_b  = 2'b00;
        ctrl.alu_op     = 2'b01;
        ctrl.result_src = 2'b00;
        ctrl.imm_src    = 2'b10;
        ctrl.pc_write   = ctrl.zero;
        state_d         = S_FETCH;
      end

      S_ILLEGAL: begin
        ctrl.illegal_instr = 1'b1;
        state_d            = S_FETCH;
      end

      default: begin
        // Unused encodings 11-15 recover exactly like an illegal opcode.
        ctrl.illegal_instr = 1'b1;
        state_d            = S_FETCH;
      end
    endcase
  end

  assign ctrl.state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: each stimulus cycle pushes its hand-computed output vector;
// a negedge monitor pops and compares against the live DUT outputs.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic rst;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BQ  = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  logic [19:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;

  logic [19:0] mon_e;
  string       mon_n;

  // {state, pc_write, adr_src, mem_write, ir_write, reg_write, result_src, a, b, imm, alu_op, illegal}
  wire [19:0] act = {bus.state, bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                     bus.reg_write, bus.result_src, bus.alu_src_a, bus.alu_src_b,
                     bus.imm_src, bus.alu_op, bus.illegal_instr};

  function automatic logic [19:0] mk(input logic [3:0] st, input logic pc, input logic adr,
                                     input logic mw, input logic ir, input logic rw,
                                     input logic [1:0] rs, input logic [1:0] a,
                                     input logic [1:0] b, input logic [1:0] imm,
                                     input logic [1:0] op, input logic ill);
    return {st, pc, adr, mw, ir, rw, rs, a, b, imm, op, ill};
  endfunction

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      checks++;
      if (act !== mon_e) begin
        errors++;
        $display("FAIL %s: got %05h expected %05h", mon_n, act, mon_e);
      end
      checks++;
      if (bus.reg_write === 1'b1 && bus.mem_write === 1'b1) begin
        errors++;
        $display("FAIL %s_wr_excl: got reg_write=%b mem_write=%b expected not both 1",
                 mon_n, bus.reg_write, bus.mem_write);
      end
    end
  end

  task automatic step(input logic r, input logic [6:0] op, input logic z, input logic mr,
                      input string n, input logic [19:0] e);
    rst           = r;
    bus.op_code   = op;
    bus.zero      = z;
    bus.mem_ready = mr;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clk);
    #1;
  endtask

  logic [19:0] f1, f0, dec, adr_l, adr_s, rd, wb, wr, xr, xi, awb, bq1, bq0, ill;

  initial begin
    f1    = mk(4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    f0    = mk(4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 1'b0);
    dec   = mk(4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b10, 2'b00, 1'b0);
    adr_l = mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0);
    adr_s = mk(4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 1'b0);
    rd    = mk(4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    wb    = mk(4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    wr    = mk(4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    xr    = mk(4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
    xi    = mk(4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 2'b10, 1'b0);
    awb   = mk(4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
    bq1   = mk(4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0);
    bq0   = mk(4'd9,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 1'b0);
    ill   = mk(4'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1);

    rst           = 1'b1;
    bus.op_code   = 7'd0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;

    // Reset held: FETCH decode visible, state pinned at 0.
    step(1'b1, LW, 1'b0, 1'b1, "rst_fetch", f1);

    // lw with mem_ready high: 0,1,2,3,4 then back to 0.
    step(1'b0, LW, 1'b0, 1'b1, "lw_fetch",  f1);
    step(1'b0, LW, 1'b0, 1'b1, "lw_decode", dec);
    step(1'b0, LW, 1'b0, 1'b1, "lw_memadr", adr_l);
    step(1'b0, LW, 1'b0, 1'b1, "lw_memrd",  rd);
    step(1'b0, LW, 1'b0, 1'b1, "lw_memwb",  wb);

    // sw with two wait cycles in MEMWR.
    step(1'b0, SW, 1'b0, 1'b1, "sw_fetch",  f1);
    step(1'b0, SW, 1'b0, 1'b1, "sw_decode", dec);
    step(1'b0, SW, 1'b0, 1'b1, "sw_memadr", adr_s);
    step(1'b0, SW, 1'b0, 1'b0, "sw_wait0",  wr);
    step(1'b0, SW, 1'b0, 1'b0, "sw_wait1",  wr);
    step(1'b0, SW, 1'b0, 1'b1, "sw_done",   wr);

    // beq taken then not taken.
    step(1'b0, BQ, 1'b1, 1'b1, "beq1_fetch",  f1);
    step(1'b0, BQ, 1'b1, 1'b1, "beq1_decode", dec);
    step(1'b0, BQ, 1'b1, 1'b1, "beq1_taken",  bq1);
    step(1'b0, BQ, 1'b0, 1'b1, "beq0_fetch",  f1);
    step(1'b0, BQ, 1'b0, 1'b1, "beq0_decode", dec);
    step(1'b0, BQ, 1'b0, 1'b1, "beq0_nottkn", bq0);

    // R-type then I-type.
    step(1'b0, RT, 1'b0, 1'b1, "r_fetch",  f1);
    step(1'b0, RT, 1'b0, 1'b1, "r_decode", dec);
    step(1'b0, RT, 1'b0, 1'b1, "r_exec",   xr);
    step(1'b0, RT, 1'b0, 1'b1, "r_aluwb",  awb);
    step(1'b0, IT, 1'b0, 1'b1, "i_fetch",  f1);
    step(1'b0, IT, 1'b0, 1'b1, "i_decode", dec);
    step(1'b0, IT, 1'b0, 1'b1, "i_exec",   xi);
    step(1'b0, IT, 1'b0, 1'b1, "i_aluwb",  awb);

    // Unsupported opcode: single illegal pulse, then FETCH.
    step(1'b0, BAD, 1'b0, 1'b1, "ill_fetch",  f1);
    step(1'b0, BAD, 1'b0, 1'b1, "ill_decode", dec);
    step(1'b0, BAD, 1'b0, 1'b1, "ill_pulse",  ill);
    step(1'b0, BAD, 1'b0, 1'b0, "ill_after",  f0);

    // Reset during MEMRD wait, then FETCH stalls while mem_ready is low.
    step(1'b0, LW, 1'b0, 1'b1, "rrd_fetch",  f1);
    step(1'b0, LW, 1'b0, 1'b1, "rrd_decode", dec);
    step(1'b0, LW, 1'b0, 1'b1, "rrd_memadr", adr_l);
    step(1'b0, LW, 1'b0, 1'b0, "rrd_wait",   rd);
    step(1'b1, LW, 1'b0, 1'b0, "rrd_rst",    rd);
    step(1'b0, LW, 1'b0, 1'b0, "rrd_stall0", f0);
    step(1'b0, LW, 1'b0, 1'b0, "rrd_stall1", f0);
    step(1'b0, LW, 1'b0, 1'b1, "rrd_go",     f1);
    step(1'b0, LW, 1'b0, 1'b1, "rrd_decode2", dec);

    // Aborted store: mem_write drops as soon as state is FETCH.
    step(1'b0, SW, 1'b0, 1'b1, "rwr_memadr", adr_s);
    step(1'b0, SW, 1'b0, 1'b0, "rwr_wait",   wr);
    step(1'b1, SW, 1'b0, 1'b0, "rwr_rst",    wr);
    step(1'b0, SW, 1'b0, 1'b0, "rwr_fetch",  f0);
    step(1'b0, SW, 1'b0, 1'b1, "rwr_go",     f1);

    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
